frame_timing_sequencer: RTL and testbench

- Generates the line and frame timing strobes (f_sync, sync, endLine, endFrame) that drive the pattern Control block.
- Holds Mode/X configuration in shadow registers and commits it to Control only at a frame start, so a pattern never changes mid-frame.
- Sits between the host configuration interface and Control; it is the only source of Control's timing and mode inputs.

---
 rtl/frame_timing_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_frame_timing_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_timing_sequencer.sv
// Purpose: line/frame timing strobe generator with shadowed Mode/X config committed at frame start.
// Latency: all outputs registered; sync appears the cycle after start is sampled in IDLE.
// Backpressure: none; timing free-runs until a stop request is honoured at a frame end.
module frame_timing_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_valid,
  input  logic [2:0]  cfg_mode,
  input  logic [1:0]  cfg_x,
  output logic        cfg_ack,
  output logic        f_sync,
  output logic        sync,
  output logic        endLine,
  output logic        endFrame,
  output logic [2:0]  Mode,
  output logic [1:0]  X,
  output logic [11:0] pix_cnt,
  output logic [11:0] line_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } state_t;

  localparam logic [11:0] HA_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HB_LAST = 12'(H_BLANK - 1);
  localparam logic [11:0] VA_LAST = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VB_LAST = 12'(V_BLANK - 1);

  state_t      r_state;
  logic [11:0] r_pix;
  logic [11:0] r_line;
  logic [11:0] r_bcnt;
  logic        r_stop_pending;
  logic        r_cfg_pending;
  logic [2:0]  r_shadow_mode;
  logic [1:0]  r_shadow_x;
  logic [2:0]  r_mode;
  logic [1:0]  r_x;
  logic        r_cfg_ack;
  logic        r_f_sync;
  logic        r_sync;
  logic        r_end_line;
  logic        r_end_frame;
  logic        r_busy;

  state_t      w_state_nxt;
  logic [11:0] w_pix_nxt;
  logic [11:0] w_line_nxt;
  logic [11:0] w_bcnt_nxt;
  logic        w_stop_clr;
  logic        w_frame_start;
  logic        w_commit;
  logic        w_end_line_nxt;

  // Next-state and counter update; blank phases share one down-the-line counter.
  always_comb begin
    w_state_nxt = r_state;
    w_pix_nxt   = r_pix;
    w_line_nxt  = r_line;
    w_bcnt_nxt  = r_bcnt;
    w_stop_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SYNC;
          w_line_nxt  = 12'd0;
          w_pix_nxt   = 12'd0;
        end
      end
      SYNC: begin
        w_state_nxt = ACTIVE;
        w_pix_nxt   = 12'd0;
      end
      ACTIVE: begin
        if (r_pix == HA_LAST) begin
          w_state_nxt = HBLANK;
          w_bcnt_nxt  = 12'd0;
        end else begin
          w_pix_nxt = r_pix + 12'd1;
        end
      end
      HBLANK: begin
        if (r_bcnt == HB_LAST) begin
          if (r_line < VA_LAST) begin
            w_line_nxt  = r_line + 12'd1;
            w_pix_nxt   = 12'd0;
            w_state_nxt = SYNC;
          end else begin
            w_state_nxt = VBLANK;
            w_bcnt_nxt  = 12'd0;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 12'd1;
        end
      end
      VBLANK: begin
        if (r_bcnt == VB_LAST) begin
          w_line_nxt = 12'd0;
          // A stop arriving in the very last blank cycle still halts this frame end.
          if (r_stop_pending || stop) begin
            w_state_nxt = IDLE;
            w_stop_clr  = 1'b1;
          end else begin
            w_state_nxt = SYNC;
            w_pix_nxt   = 12'd0;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 12'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Strobes are decoded from next-state so they line up with the registered state.
  always_comb begin
    w_frame_start  = (w_state_nxt == SYNC) && (w_line_nxt == 12'd0);
    w_commit       = w_frame_start && r_cfg_pending;
    w_end_line_nxt = (w_state_nxt == ACTIVE) && (w_pix_nxt == HA_LAST);
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pix   <= 12'd0;
      r_line  <= 12'd0;
      r_bcnt  <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pix   <= w_pix_nxt;
      r_line  <= w_line_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Stop request latch: ignored in IDLE unless it coincides with start (single-frame run).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stop_pending <= 1'b0;
    end else if (w_stop_clr) begin
      r_stop_pending <= 1'b0;
    end else if (stop && ((r_state != IDLE) || start)) begin
      r_stop_pending <= 1'b1;
    end
  end

  // Shadow config; a write coinciding with a commit stays pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_mode <= 3'b000;
      r_shadow_x    <= 2'b00;
      r_cfg_pending <= 1'b0;
      r_mode        <= 3'b000;
      r_x           <= 2'b00;
      r_cfg_ack     <= 1'b0;
    end else begin
      r_cfg_ack     <= w_commit;
      r_cfg_pending <= cfg_valid || (r_cfg_pending && !w_commit);
      if (w_commit) begin
        r_mode <= r_shadow_mode;
        r_x    <= r_shadow_x;
      end
      if (cfg_valid) begin
        r_shadow_mode <= cfg_mode;
        r_shadow_x    <= cfg_x;
      end
    end
  end

  // Registered timing strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= 1'b0;
      r_f_sync    <= 1'b0;
      r_end_line  <= 1'b0;
      r_end_frame <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sync      <= (w_state_nxt == SYNC);
      r_f_sync    <= w_frame_start;
      r_end_line  <= w_end_line_nxt;
      r_end_frame <= w_end_line_nxt && (w_line_nxt == VA_LAST);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign cfg_ack  = r_cfg_ack;
  assign f_sync   = r_f_sync;
  assign sync     = r_sync;
  assign endLine  = r_end_line;
  assign endFrame = r_end_frame;
  assign Mode     = r_mode;
  assign X        = r_x;
  assign pix_cnt  = r_pix;
  assign line_cnt = r_line;
  assign busy     = r_busy;

endmodule

// File: tb/tb_frame_timing_sequencer.sv
// Purpose: scoreboard bench for frame_timing_sequencer with a small timing geometry.
// Latency: expected strobe events carry the absolute cycle they must appear in.
// Backpressure: not applicable; the monitor pops one expected event per strobe cycle.
module tb_frame_timing_sequencer;

  localparam int HA = 8;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int VB = 4;
  localparam int LP = 1 + HA + HB;     // 11
  localparam int FP = VA * LP + VB;    // 37

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic [2:0]  cfg_mode;
  logic [1:0]  cfg_x;
  logic        cfg_ack;
  logic        f_sync;
  logic        sync;
  logic        endLine;
  logic        endFrame;
  logic [2:0]  Mode;
  logic [1:0]  X;
  logic [11:0] pix_cnt;
  logic [11:0] line_cnt;
  logic        busy;

  typedef struct {
    int          cyc;
    logic        sync;
    logic        fsync;
    logic        el;
    logic        ef;
    logic        ack;
    logic [2:0]  mode;
    logic [1:0]  x;
    logic [11:0] pix;
    logic [11:0] line;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;
  int  cyc;
  int  checks;
  int  errors;
  int  t1, t2, t6;

  frame_timing_sequencer #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_x(cfg_x),
    .cfg_ack(cfg_ack), .f_sync(f_sync), .sync(sync),
    .endLine(endLine), .endFrame(endFrame), .Mode(Mode), .X(X),
    .pix_cnt(pix_cnt), .line_cnt(line_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic s, input logic fs, input logic el,
                         input logic ef, input logic ack, input logic [2:0] m,
                         input logic [1:0] x, input int pix, input int line);
    ev_t v;
    v.cyc = c; v.sync = s; v.fsync = fs; v.el = el; v.ef = ef; v.ack = ack;
    v.mode = m; v.x = x; v.pix = 12'(pix); v.line = 12'(line);
    exp_q.push_back(v);
  endtask

  // Expected events of one line: sync at s, endLine on the last active pixel.
  task automatic push_line(input int s, input int l, input logic [2:0] m,
                           input logic [1:0] x, input logic ack);
    push_ev(s, 1'b1, l == 0, 1'b0, 1'b0, ack && (l == 0), m, x, 0, l);
    push_ev(s + HA, 1'b0, 1'b0, 1'b1, l == VA - 1, 1'b0, m, x, HA - 1, l);
  endtask

  task automatic push_frame(input int t, input logic [2:0] m, input logic [1:0] x,
                            input logic ack);
    for (int l = 0; l < VA; l++) push_line(t + LP * l, l, m, x, ack);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every strobe cycle must match the next expected event exactly.
  always @(negedge clk) begin
    if (!rst && (sync || f_sync || endLine || endFrame || cfg_ack)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: cyc %0d got sync=%b fsync=%b el=%b ef=%b ack=%b, expected no strobe",
                 cyc, sync, f_sync, endLine, endFrame, cfg_ack);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.sync != sync || e.fsync != f_sync || e.el != endLine ||
            e.ef != endFrame || e.ack != cfg_ack || e.mode != Mode || e.x != X ||
            e.pix != pix_cnt || e.line != line_cnt) begin
          errors++;
          $display("FAIL strobe_event: got cyc=%0d s=%b fs=%b el=%b ef=%b ack=%b mode=%0d x=%0d pix=%0d line=%0d; expected cyc=%0d s=%b fs=%b el=%b ef=%b ack=%b mode=%0d x=%0d pix=%0d line=%0d",
                   cyc, sync, f_sync, endLine, endFrame, cfg_ack, Mode, X, pix_cnt, line_cnt,
                   e.cyc, e.sync, e.fsync, e.el, e.ef, e.ack, e.mode, e.x, e.pix, e.line);
        end
      end
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_mode = 3'b000; cfg_x = 2'b00;
    #1;
    check("reset_busy", busy, 0);
    check("reset_strobes", {sync, f_sync, endLine, endFrame, cfg_ack}, 0);
    check("reset_mode_x", {Mode, X}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Test 1: run into line 1, then reset mid-ACTIVE.
    wait_cyc(4);
    start = 1'b1; t1 = cyc + 1;
    push_line(t1, 0, 3'b000, 2'b00, 1'b0);
    push_ev(t1 + LP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 0, 1);
    @(negedge clk); start = 1'b0;
    wait_cyc(t1 + LP + 3);
    check("pre_reset_line", line_cnt, 1);
    check("pre_reset_pix", pix_cnt, 2);
    rst = 1'b1;
    #1;
    check("midframe_reset_outputs",
          {sync, f_sync, endLine, endFrame, cfg_ack, busy, Mode, X, pix_cnt, line_cnt}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    wait_cyc(t1 + LP + 45);
    check("idle_after_reset_busy", busy, 0);
    check("test1_queue_drained", exp_q.size(), 0);

    // Test 2/3/4/5: config in IDLE, free run, mid-frame writes, stop in line 0 of frame 2.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_mode = 3'b001; cfg_x = 2'b01;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b1; t2 = cyc + 1;
    push_frame(t2, 3'b001, 2'b01, 1'b1);
    push_frame(t2 + FP, 3'b011, 2'b11, 1'b1);
    @(negedge clk); start = 1'b0;
    wait_cyc(t2 + LP + 2);
    cfg_valid = 1'b1; cfg_mode = 3'b010; cfg_x = 2'b10;
    @(negedge clk); cfg_valid = 1'b0;
    wait_cyc(t2 + 2 * LP + 2);
    cfg_valid = 1'b1; cfg_mode = 3'b011; cfg_x = 2'b11;
    @(negedge clk); cfg_valid = 1'b0;
    check("mode_held_midframe", {Mode, X}, {3'b001, 2'b01});
    // Write sampled on the same edge as frame 2's commit: lands in the shadow only.
    wait_cyc(t2 + FP - 1);
    cfg_valid = 1'b1; cfg_mode = 3'b101; cfg_x = 2'b10;
    @(negedge clk); cfg_valid = 1'b0;
    wait_cyc(t2 + FP + 3);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_cyc(t2 + FP + 20);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_cyc(t2 + 2 * FP - 2);
    check("vblank_busy", busy, 1);
    check("vblank_line", line_cnt, VA - 1);
    wait_cyc(t2 + 2 * FP);
    check("stopped_busy", busy, 0);
    check("stopped_line", line_cnt, 0);
    check("stopped_mode_x", {Mode, X}, {3'b011, 2'b11});
    check("test2_queue_drained", exp_q.size(), 0);

    // Test 6: start and stop together -> exactly one frame, committing the late write.
    wait_cyc(t2 + 2 * FP + 10);
    start = 1'b1; stop = 1'b1; t6 = cyc + 1;
    push_frame(t6, 3'b101, 2'b10, 1'b1);
    @(negedge clk); start = 1'b0; stop = 1'b0;
    wait_cyc(t6 + FP + 1);
    check("single_frame_busy", busy, 0);
    wait_cyc(t6 + FP + 30);
    check("single_frame_mode_x", {Mode, X}, {3'b101, 2'b10});
    check("final_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
